// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access-size encodings
// and the transaction FSM state type.
package lsu_pkg;

    localparam logic [1:0] DMEM_EXT_BYTE = 2'b00;
    localparam logic [1:0] DMEM_EXT_HALF = 2'b01;
    localparam logic [1:0] DMEM_EXT_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/dmem_ext.sv
// Load data lane selection and sign/zero extension for byte and half accesses;
// word accesses pass the bus data through untouched.
module dmem_ext
    import lsu_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half lanes ignore offset[0], so a misaligned half reads as if aligned.
    always_comb begin
        byte_lane = raw_data[7:0];
        case (offset)
            2'd0: byte_lane = raw_data[7:0];
            2'd1: byte_lane = raw_data[15:8];
            2'd2: byte_lane = raw_data[23:16];
            2'd3: byte_lane = raw_data[31:24];
            default: byte_lane = raw_data[7:0];
        endcase
        half_lane = offset[1] ? raw_data[31:16] : raw_data[15:0];
    end

    always_comb begin
        ext_data = raw_data;
        case (size)
            DMEM_EXT_BYTE: ext_data = {{24{~unsign & byte_lane[7]}}, byte_lane};
            DMEM_EXT_HALF: ext_data = {{16{~unsign & half_lane[15]}}, half_lane};
            default:       ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit bridging a single-request core port to a word-wide memory bus.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module dmem_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic        core_wen,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [1:0]  core_ext_size,
    input  logic        core_ext_unsign,
    output logic        core_rsp_valid,
    output logic [31:0] core_rsp_rdata,
    output logic        core_busy,
    output logic        misalign_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_next;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsign_q;
    logic [31:0] rdata_q;
    logic [31:0] ext_data;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_strb;
    logic        accept;
    logic        misaligned;

    assign accept = (state == ST_IDLE) && core_req_valid;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    assign misaligned = ((core_ext_size == DMEM_EXT_HALF) && core_addr[0]) ||
                        (core_ext_size[1] && (core_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept)
            err_q <= misaligned;
    end

    assign misalign_err = (state == ST_RESP) && err_q;
`else
    assign misaligned   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= DMEM_EXT_BYTE;
            unsign_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                wen_q    <= core_wen;
                addr_q   <= core_addr;
                wdata_q  <= core_wdata;
                size_q   <= core_ext_size;
                unsign_q <= core_ext_unsign;
                rdata_q  <= '0;
            end else if ((state == ST_WAIT) && mem_rsp_valid) begin
                rdata_q <= ext_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (core_req_valid) state_next = misaligned ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_req_ready)  state_next = wen_q ? ST_RESP : ST_WAIT;
            ST_WAIT: if (mem_rsp_valid)  state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Store data is replicated across lanes so the strobes alone pick the bytes written.
    always_comb begin
        lane_wdata = wdata_q;
        lane_strb  = 4'b1111;
        case (size_q)
            DMEM_EXT_BYTE: begin
                lane_wdata = {4{wdata_q[7:0]}};
                lane_strb  = 4'b0001 << addr_q[1:0];
            end
            DMEM_EXT_HALF: begin
                lane_wdata = {2{wdata_q[15:0]}};
                lane_strb  = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = wdata_q;
                lane_strb  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = 4'b0000;
        if (state == ST_REQ) begin
            mem_req_valid = 1'b1;
            mem_wen       = wen_q;
            mem_addr      = {addr_q[31:2], 2'b00};
            mem_wdata     = wen_q ? lane_wdata : 32'h0;
            mem_wstrb     = wen_q ? lane_strb : 4'b0000;
        end
    end

    dmem_ext u_ext (
        .raw_data (mem_rdata),
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .unsign   (unsign_q),
        .ext_data (ext_data)
    );

    assign core_req_ready = (state == ST_IDLE);
    assign core_busy      = (state != ST_IDLE);
    assign core_rsp_valid = (state == ST_RESP);
    assign core_rsp_rdata = (state == ST_RESP) ? rdata_q : 32'h0;

endmodule
